// File: rtl/modulo_pkg.sv
// Shared definitions for the modulo-ADC transmit encoder and the reconstruction chain.
// Holds the FSM state type, default fold window and the code-scaling constants.
package modulo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FOLD,
        SCALE,
        HOLD
    } fold_state_t;

    localparam int          ADC_BITS           = 12;
    localparam int          FOLD_COUNT_BITS    = 8;
    localparam logic [23:0] DEFAULT_LAMBDA     = 24'h00C000;
    localparam logic [23:0] DEFAULT_CODE_SCALE = 24'h0AAAAB;

endpackage

// File: rtl/modulo_fold_encoder_if.sv
// Sample-in / code-out handshake bundle of the modulo fold encoder.
// The master drives samples and acceptance; the slave returns the folded code.
interface modulo_fold_encoder_if
    import modulo_pkg::*;
#(
    parameter int WIDTH = 24
);
    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTH-1:0]           x_in;
    logic                       out_valid;
    logic                       out_ready;
    logic [ADC_BITS-1:0]        adc_code;
    logic [FOLD_COUNT_BITS-1:0] fold_count;
    logic                       fold_overflow;

    modport master (
        output in_valid, x_in, out_ready,
        input  in_ready, out_valid, adc_code, fold_count, fold_overflow
    );

    modport slave (
        input  in_valid, x_in, out_ready,
        output in_ready, out_valid, adc_code, fold_count, fold_overflow
    );
endinterface

// File: rtl/adc_code_quantizer.sv
// Maps a folded sample in [-LAMBDA, LAMBDA) onto the unsigned ADC code range.
// Purely combinational; the parent registers the result.
module adc_code_quantizer
    import modulo_pkg::*;
#(
    parameter int               WIDTH           = 24,
    parameter int               FRACTIONAL_BITS = 16,
    parameter logic [WIDTH-1:0] LAMBDA          = DEFAULT_LAMBDA,
    parameter logic [WIDTH-1:0] CODE_SCALE      = DEFAULT_CODE_SCALE
) (
    input  logic signed [WIDTH:0] x_i,
    input  logic                  ovf_i,
    output logic [ADC_BITS-1:0]   code_o
);
    localparam int PW = 48;
    localparam logic signed [PW-1:0] LAMBDA_W = {{(PW-WIDTH){1'b0}}, LAMBDA};
    localparam logic signed [PW-1:0] SCALE_W  = {{(PW-WIDTH){1'b0}}, CODE_SCALE};
    localparam logic signed [PW-1:0] CODE_MAX = {{(PW-ADC_BITS){1'b0}}, {ADC_BITS{1'b1}}};

    logic signed [PW-1:0] offset;
    logic signed [PW-1:0] product;
    logic signed [PW-1:0] shifted;

    always_comb begin
        offset  = {{(PW-WIDTH-1){x_i[WIDTH]}}, x_i} + LAMBDA_W;
        product = offset * SCALE_W;
        shifted = product >>> (FRACTIONAL_BITS + 8);
        // An unfinished fold leaves x outside the window; pin to the rail matching its sign.
        if (ovf_i) begin
            code_o = x_i[WIDTH] ? '0 : '1;
        end else if (shifted[PW-1]) begin
            code_o = '0;
        end else if (shifted > CODE_MAX) begin
            code_o = '1;
        end else begin
            code_o = shifted[ADC_BITS-1:0];
        end
    end
endmodule

// File: rtl/modulo_fold_encoder.sv
// Folds Q8.16 samples into [-LAMBDA, LAMBDA) by repeated 2*LAMBDA steps and emits
// the 12-bit ADC code plus the net fold count; state advances on the falling edge.
module modulo_fold_encoder
    import modulo_pkg::*;
#(
    parameter int               WIDTH           = 24,
    parameter int               FRACTIONAL_BITS = 16,
    parameter logic [WIDTH-1:0] LAMBDA          = DEFAULT_LAMBDA,
    parameter logic [WIDTH-1:0] CODE_SCALE      = DEFAULT_CODE_SCALE,
    parameter int               MAX_FOLDS       = 127
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_en,
    modulo_fold_encoder_if.slave bus
);
    // One guard bit so x +/- 2*LAMBDA never wraps.
    localparam logic signed [WIDTH:0] LAM     = {1'b0, LAMBDA};
    localparam logic signed [WIDTH:0] NEG_LAM = -LAM;
    localparam logic signed [WIDTH:0] TWO_LAM = {LAMBDA, 1'b0};
    localparam logic [6:0]            ITER_MAX = 7'(MAX_FOLDS);
    localparam logic signed [7:0]     K_MAX    = 8'sh7F;
    localparam logic signed [7:0]     K_MIN    = 8'sh80;

    fold_state_t           state_q, state_d;
    logic signed [WIDTH:0] x_q, x_d;
    logic signed [7:0]     k_q, k_d;
    logic [6:0]            iter_q, iter_d;
    logic                  ovf_q, ovf_d;
    logic                  out_valid_q, out_valid_d;
    logic [ADC_BITS-1:0]   adc_code_q, adc_code_d;
    logic signed [7:0]     fold_count_q, fold_count_d;
    logic                  fold_overflow_q, fold_overflow_d;
    logic [ADC_BITS-1:0]   quant_code;
    logic                  above, below;

    assign above = (x_q >= LAM);
    assign below = (x_q < NEG_LAM);

    adc_code_quantizer #(
        .WIDTH          (WIDTH),
        .FRACTIONAL_BITS(FRACTIONAL_BITS),
        .LAMBDA         (LAMBDA),
        .CODE_SCALE     (CODE_SCALE)
    ) u_quantizer (
        .x_i   (x_q),
        .ovf_i (ovf_q),
        .code_o(quant_code)
    );

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            x_q             <= '0;
            k_q             <= '0;
            iter_q          <= '0;
            ovf_q           <= 1'b0;
            out_valid_q     <= 1'b0;
            adc_code_q      <= '0;
            fold_count_q    <= '0;
            fold_overflow_q <= 1'b0;
        end else if (clk_en) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q         <= state_d;
            x_q             <= x_d;
            k_q             <= k_d;
            iter_q          <= iter_d;
            ovf_q           <= ovf_d;
            out_valid_q     <= out_valid_d;
            adc_code_q      <= adc_code_d;
            fold_count_q    <= fold_count_d;
            fold_overflow_q <= fold_overflow_d;
        end
    end

    always_comb begin
        // NOTE: each _d defaults to its _q so branches that skip it cannot infer a latch.
        state_d         = state_q;
        x_d             = x_q;
        k_d             = k_q;
        iter_d          = iter_q;
        ovf_d           = ovf_q;
        out_valid_d     = out_valid_q;
        adc_code_d      = adc_code_q;
        fold_count_d    = fold_count_q;
        fold_overflow_d = fold_overflow_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d     = {bus.x_in[WIDTH-1], bus.x_in};
                    k_d     = '0;
                    iter_d  = '0;
                    ovf_d   = 1'b0;
                    state_d = FOLD;
                end
            end
            FOLD: begin
                if (above || below) begin
                    if (iter_q == ITER_MAX) begin
                        ovf_d   = 1'b1;
                        state_d = SCALE;
                    end else if (above) begin
                        x_d    = x_q - TWO_LAM;
                        k_d    = (k_q == K_MAX) ? k_q : k_q + 8'sd1;
                        iter_d = iter_q + 7'd1;
                    end else begin
                        x_d    = x_q + TWO_LAM;
                        k_d    = (k_q == K_MIN) ? k_q : k_q - 8'sd1;
                        iter_d = iter_q + 7'd1;
                    end
                end else begin
                    state_d = SCALE;
                end
            end
            SCALE: begin
                adc_code_d      = quant_code;
                fold_count_d    = k_q;
                fold_overflow_d = ovf_q;
                out_valid_d     = 1'b1;
                state_d         = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready      = (state_q == IDLE) && !reset;
        bus.out_valid     = out_valid_q;
        bus.adc_code      = adc_code_q;
        bus.fold_count    = fold_count_q;
        bus.fold_overflow = fold_overflow_q;
    end
endmodule
